parallel_serial_shift_reg: RTL and testbench

- Parallel-in, serial-out (PISO) shift register.
- A one-cycle enable loads an INPUT_WIDTH-bit word; the word is then shifted out MSB-first, one bit per clock, on data_out.
- Sits between a parallel producer and a single-wire serial consumer.
- Provides busy/done status so the producer can pace loads.

---
 rtl/psr_pkg.sv | 13 +
 rtl/psr_bit_counter.sv | 36 +++
 rtl/parallel_serial_shift_reg.sv | 88 ++++++++
 tb/tb_parallel_serial_shift_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared definitions for the parallel-in, serial-out shift register.
//   psr_cnt_w(n) : width of a down-counter that can hold the value n,
//                  i.e. $clog2(n+1).
//   PSR_FILL_BIT : bit shifted into the LSB on every shift.
package psr_pkg;

  localparam logic PSR_FILL_BIT = 1'b0;

  function automatic int psr_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/psr_bit_counter.sv
// Loadable down-counter with a terminal-count flag.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   count    : current count
//   tc       : high when count is zero
module psr_bit_counter
  import psr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/parallel_serial_shift_reg.sv
// Parallel-in, serial-out shift register. A one-cycle enable loads a word
// which is then shifted out MSB first, one bit per clock.
// Optional build macro PSR_PARITY_EN: appends one even-parity bit (XOR of
// the loaded word, latched at load) after bit 0; busy covers that cycle.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   enable   : load strobe; reloads (and aborts any frame) when high
//   data_in  : parallel word, sampled when enable=1
//   data_out : serial bit stream, MSB first, 0 when idle
//   busy     : high while a frame is on data_out
//   done     : one-cycle pulse after the last bit of a completed frame
module parallel_serial_shift_reg
  import psr_pkg::*;
#(
  parameter int INPUT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] data_in,
  output logic                   data_out,
  output logic                   busy,
  output logic                   done
);

`ifdef PSR_PARITY_EN
  localparam int FRAME_LEN = INPUT_WIDTH + 1;
`else
  localparam int FRAME_LEN = INPUT_WIDTH;
`endif
  localparam int CNT_W = psr_cnt_w(INPUT_WIDTH);

  // The parity bit (when enabled) rides in the LSB of the shift register so
  // it simply falls out after bit 0; data_out is always the register MSB.
  logic [FRAME_LEN-1:0] sr_q;
  logic [FRAME_LEN-1:0] load_word;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 last_bit;
  logic                 shift_en;

`ifdef PSR_PARITY_EN
  assign load_word = {data_in, ^data_in};
`else
  assign load_word = data_in;
`endif

  assign shift_en = busy & ~enable & ~last_bit;

  psr_bit_counter #(
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (enable),
    .load_val(CNT_W'(FRAME_LEN - 1)),
    .dec     (shift_en),
    .count   (bit_cnt),
    .tc      (last_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (enable) begin
      sr_q <= load_word;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      if (!last_bit) begin
        sr_q <= {sr_q[FRAME_LEN-2:0], PSR_FILL_BIT};
        done <= 1'b0;
      end else begin
        // Clearing the register here makes data_out read 0 while idle.
        sr_q <= '0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign data_out = sr_q[FRAME_LEN-1];

endmodule

// File: tb/tb_parallel_serial_shift_reg.sv
module tb_parallel_serial_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the bits still to appear on data_out, front = now.
  bit q[$];
  bit done_m = 1'b0;

  parallel_serial_shift_reg #(.INPUT_WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .data_in (data_in),
    .data_out(data_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [W-1:0] d);
    if (!r) begin
      q.delete();
      done_m = 1'b0;
    end else if (en) begin
      q.delete();
      for (int k = W - 1; k >= 0; k--) q.push_back(d[k]);
`ifdef PSR_PARITY_EN
      q.push_back(^d);
`endif
      done_m = 1'b0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
      done_m = (q.size() == 0);
    end else begin
      done_m = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'((q.size() > 0) ? q[0] : 1'b0));
    chk({tag, ".busy"},     32'(busy),     32'(q.size() > 0));
    chk({tag, ".done"},     32'(done),     32'(done_m));
  endtask

  // Drive inputs (just after an edge), clock once, update model, check.
  task automatic step(input logic r, input logic en, input logic [W-1:0] d, input string tag);
    reset   = r;
    enable  = en;
    data_in = d;
    @(posedge clk);
    model_edge(r, en, d);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, tag);
  endtask

  logic [W-1:0] pat;
  int           done_cnt;

  initial begin
    // Reset held with enable high and all-ones data.
    step(1'b0, 1'b1, 8'hFF, "reset0");
    chk("reset0.out_zero", 32'({data_out, busy, done}), 32'd0);
    step(1'b0, 1'b1, 8'hFF, "reset1");
    chk("reset1.out_zero", 32'({data_out, busy, done}), 32'd0);
    idle(2, "post_reset");

    // Basic frame with explicit expected values.
    pat = 8'b10101010;
    step(1'b1, 1'b1, pat, "basic_load");
    for (int i = 0; i < W; i++) begin
      chk("basic.bit", 32'(data_out), 32'(pat[W-1-i]));
      chk("basic.busy", 32'(busy), 32'd1);
      if (i < W - 1) step(1'b1, 1'b0, '0, "basic_shift");
    end
`ifdef PSR_PARITY_EN
    step(1'b1, 1'b0, '0, "basic_par");
    chk("basic.parity", 32'(data_out), 32'd0);
`endif
    step(1'b1, 1'b0, '0, "basic_end");
    chk("basic.done", 32'(done), 32'd1);
    chk("basic.busy_low", 32'(busy), 32'd0);
    idle(1, "basic_idle");
    chk("basic.done_once", 32'(done), 32'd0);
    chk("basic.out_idle", 32'(data_out), 32'd0);
    idle(2, "basic_idle2");

    // Reload mid-frame: F0, three bits, then 0F.
    step(1'b1, 1'b1, 8'hF0, "reload_a");
    idle(2, "reload_a_sh");
    step(1'b1, 1'b1, 8'h0F, "reload_b");
    idle(W + 3, "reload_b_sh");

    // Back-to-back: 81 then 7E loaded on the end-of-frame edge.
    step(1'b1, 1'b1, 8'h81, "b2b_a");
    idle(W - 1, "b2b_a_sh");
    step(1'b1, 1'b1, 8'h7E, "b2b_b");
    chk("b2b.busy_kept", 32'(busy), 32'd1);
    chk("b2b.no_done", 32'(done), 32'd0);
    idle(W + 3, "b2b_b_sh");

    // Asynchronous reset between edges during bit 4.
    step(1'b1, 1'b1, 8'hFF, "arst_load");
    idle(4, "arst_sh");
    #2 reset = 1'b0;
    #1;
    chk("arst.data_out", 32'(data_out), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    q.delete();
    done_m = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, '0, "arst_rel");
    idle(W + 2, "arst_idle");

`ifdef PSR_PARITY_EN
    // Parity bit after the data bits.
    step(1'b1, 1'b1, 8'b10000000, "par_load");
    idle(W - 1, "par_data");
    step(1'b1, 1'b0, '0, "par_bit");
    chk("par.bit_one", 32'(data_out), 32'd1);
    step(1'b1, 1'b0, '0, "par_end");
    chk("par.done_10th", 32'(done), 32'd1);
    idle(2, "par_idle");
`endif

    // Randomised traffic including holds, reloads and rare resets.
    done_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      int   r;
      logic rr, ee;
      r  = $urandom_range(0, 99);
      rr = (r != 0);
      ee = (r >= 1 && r < 12) || (r >= 12 && r < 14 && busy);
      step(rr, ee, W'($urandom), "rand");
      if (done) done_cnt++;
    end
    chk("rand.some_done", 32'(done_cnt > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
